// File: rtl/axi_rt_counter_pkg.sv
// Shared types and saturating arithmetic helpers for the RT unit budget counters.
// Helpers operate on a fixed 64-bit container; callers zero-extend in and truncate out.
package axi_rt_counter_pkg;

    typedef enum logic {
        RELOAD = 1'b0,
        CARRY  = 1'b1
    } replenish_mode_e;

    localparam int unsigned MaxCntWidth = 64;

    typedef logic [MaxCntWidth-1:0] cnt_t;

    function automatic cnt_t sat_sub(input cnt_t a, input cnt_t b);
        return (b > a) ? '0 : (a - b);
    endfunction

    // One extra bit holds the carry, so the sum never wraps before the cap.
    function automatic cnt_t cap_add(input cnt_t a, input cnt_t b, input cnt_t cap);
        logic [MaxCntWidth:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, cap}) ? cap : sum[MaxCntWidth-1:0];
    endfunction

endpackage

// File: rtl/axi_rt_unit_budget_chan.sv
// One byte-budget channel: replenish base, spend with zero saturation, overrun pulse.
// AXI_RT_UNIT_COUNTER_OVERRUN_STATS_EN adds a saturating overrun statistic counter.
module axi_rt_unit_budget_chan
    import axi_rt_counter_pkg::*;
#(
    parameter int unsigned BudgetWidth = 32,
    parameter int unsigned StatWidth   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   repl_i,
    input  logic                   ax_happening_i,
    input  logic [BudgetWidth-1:0] ax_bytes_i,
    input  logic [BudgetWidth-1:0] budget_i,
    input  logic [BudgetWidth-1:0] credit_cap_i,
    input  replenish_mode_e        mode_i,
    output logic [BudgetWidth-1:0] budget_left_o,
    output logic                   budget_spent_o,
    output logic                   overrun_o,
    output logic [StatWidth-1:0]   overrun_cnt_o
);

    logic [BudgetWidth-1:0] budget_q, budget_d;
    logic [BudgetWidth-1:0] base_val;
    logic                   overrun_q, overrun_d;
    logic                   spend;

    // A transaction coinciding with a replenish is charged against the new value.
    always_comb begin
        base_val = budget_q;
        if (repl_i) begin
            if (mode_i == CARRY) begin
                base_val = BudgetWidth'(cap_add(cnt_t'(budget_q), cnt_t'(budget_i),
                                                cnt_t'(credit_cap_i)));
            end else begin
                base_val = budget_i;
            end
        end
        spend     = enable_i & ax_happening_i & (base_val != '0);
        budget_d  = base_val;
        overrun_d = 1'b0;
        if (spend) begin
            budget_d  = BudgetWidth'(sat_sub(cnt_t'(base_val), cnt_t'(ax_bytes_i)));
            overrun_d = (ax_bytes_i > base_val);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            budget_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            budget_q  <= budget_d;
            overrun_q <= overrun_d;
        end
    end

    assign budget_left_o  = budget_q;
    assign budget_spent_o = (budget_q == '0);
    assign overrun_o      = overrun_q;

`ifdef AXI_RT_UNIT_COUNTER_OVERRUN_STATS_EN
    logic [StatWidth-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (overrun_q && (stat_q != '1)) begin
            stat_d = stat_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign overrun_cnt_o = stat_q;
`else
    assign overrun_cnt_o = '0;
`endif

endmodule

// File: rtl/axi_rt_unit_counter_mc.sv
// Multi-channel RT unit counter: shared period down-counter driving NumChannels budget channels.
// Optional per-channel overrun statistics via AXI_RT_UNIT_COUNTER_OVERRUN_STATS_EN.
module axi_rt_unit_counter_mc
    import axi_rt_counter_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned PeriodWidth = 32,
    parameter int unsigned BudgetWidth = 32,
    parameter type         ax_bytes_t  = logic [BudgetWidth-1:0],
    parameter int unsigned StatWidth   = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    enable_i,
    input  logic [PeriodWidth-1:0]                  period_i,
    input  logic                                    period_abort_i,
    output logic [PeriodWidth-1:0]                  period_left_o,
    output logic                                    period_over_o,
    input  logic [NumChannels-1:0]                  ax_happening_i,
    input  ax_bytes_t [NumChannels-1:0]             ax_bytes_i,
    input  logic [NumChannels-1:0][BudgetWidth-1:0] budget_i,
    input  logic [NumChannels-1:0][BudgetWidth-1:0] credit_cap_i,
    input  logic [NumChannels-1:0]                  mode_i,
    output logic [NumChannels-1:0][BudgetWidth-1:0] budget_left_o,
    output logic [NumChannels-1:0]                  budget_spent_o,
    output logic [NumChannels-1:0]                  overrun_o,
    output logic [NumChannels-1:0][StatWidth-1:0]   overrun_cnt_o
);

    logic [PeriodWidth-1:0] period_q, period_d;
    logic                   repl;

    // Replenish ignores enable_i so the first cycle out of reset loads everything.
    assign repl = (period_q == '0) | period_abort_i;

    always_comb begin
        period_d = period_q;
        if (repl) begin
            period_d = period_i;
        end else if (enable_i) begin
            period_d = period_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end

    assign period_left_o = period_q;
    assign period_over_o = repl;

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
        axi_rt_unit_budget_chan #(
            .BudgetWidth (BudgetWidth),
            .StatWidth   (StatWidth)
        ) u_chan (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .enable_i       (enable_i),
            .repl_i         (repl),
            .ax_happening_i (ax_happening_i[gi]),
            .ax_bytes_i     (BudgetWidth'(ax_bytes_i[gi])),
            .budget_i       (budget_i[gi]),
            .credit_cap_i   (credit_cap_i[gi]),
            .mode_i         (replenish_mode_e'(mode_i[gi])),
            .budget_left_o  (budget_left_o[gi]),
            .budget_spent_o (budget_spent_o[gi]),
            .overrun_o      (overrun_o[gi]),
            .overrun_cnt_o  (overrun_cnt_o[gi])
        );
    end

endmodule

// File: tb/tb_axi_rt_unit_counter_mc.sv
// Scoreboard bench for axi_rt_unit_counter_mc: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them. Honours AXI_RT_UNIT_COUNTER_OVERRUN_STATS_EN.
module tb_axi_rt_unit_counter_mc;

    localparam int unsigned NCH = 2;
    localparam int unsigned PW  = 32;
    localparam int unsigned BW  = 32;
    localparam int unsigned SW  = 2;
`ifdef AXI_RT_UNIT_COUNTER_OVERRUN_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic [PW-1:0]           period;
    logic                    period_abort;
    logic [PW-1:0]           period_left;
    logic                    period_over;
    logic [NCH-1:0]          ax_happening;
    logic [NCH-1:0][BW-1:0]  ax_bytes;
    logic [NCH-1:0][BW-1:0]  budget;
    logic [NCH-1:0][BW-1:0]  credit_cap;
    logic [NCH-1:0]          mode;
    logic [NCH-1:0][BW-1:0]  budget_left;
    logic [NCH-1:0]          budget_spent;
    logic [NCH-1:0]          overrun;
    logic [NCH-1:0][SW-1:0]  overrun_cnt;

    always #5 clk = ~clk;

    axi_rt_unit_counter_mc #(
        .NumChannels (NCH),
        .PeriodWidth (PW),
        .BudgetWidth (BW),
        .StatWidth   (SW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .period_i       (period),
        .period_abort_i (period_abort),
        .period_left_o  (period_left),
        .period_over_o  (period_over),
        .ax_happening_i (ax_happening),
        .ax_bytes_i     (ax_bytes),
        .budget_i       (budget),
        .credit_cap_i   (credit_cap),
        .mode_i         (mode),
        .budget_left_o  (budget_left),
        .budget_spent_o (budget_spent),
        .overrun_o      (overrun),
        .overrun_cnt_o  (overrun_cnt)
    );

    typedef enum int {SEL_PLEFT, SEL_POVER, SEL_BLEFT, SEL_SPENT, SEL_OVR, SEL_OCNT} sel_e;

    typedef struct {
        int unsigned cyc;
        sel_e        sel;
        int          ch;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          draining = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input sel_e sel, input int ch, input logic [31:0] v);
        sb.push_back('{cyc, sel, ch, v, name});
    endtask

    // Monitor: outputs are presented every cycle; compare everything due this cycle.
    always @(negedge clk) begin
        exp_t        it;
        logic [31:0] act;
        while (sb.size() > 0 && (draining || sb[0].cyc <= cyc)) begin
            it = sb.pop_front();
            n_cmp++;
            if (it.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s ch%0d: check due at cycle %0d never sampled (now %0d), expected %0h",
                         it.name, it.ch, it.cyc, cyc, it.exp);
            end else begin
                case (it.sel)
                    SEL_PLEFT: act = period_left;
                    SEL_POVER: act = {31'd0, period_over};
                    SEL_BLEFT: act = budget_left[it.ch];
                    SEL_SPENT: act = {31'd0, budget_spent[it.ch]};
                    SEL_OVR:   act = {31'd0, overrun[it.ch]};
                    default:   act = {30'd0, overrun_cnt[it.ch]};
                endcase
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s ch%0d cyc%0d: got %0h expected %0h",
                             it.name, it.ch, cyc, act, it.exp);
                end else begin
                    $display("ok   %s ch%0d cyc%0d: %0h", it.name, it.ch, cyc, act);
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        period       = '0;
        period_abort = 1'b0;
        ax_happening = '0;
        ax_bytes     = '0;
        budget       = '0;
        credit_cap   = '0;
        mode         = '0;
        step(2);
        chk("rst_pleft", SEL_PLEFT, 0, 0);
        chk("rst_pover", SEL_POVER, 0, 1);
        chk("rst_bleft0", SEL_BLEFT, 0, 0);
        chk("rst_bleft1", SEL_BLEFT, 1, 0);
        chk("rst_spent0", SEL_SPENT, 0, 1);
        chk("rst_spent1", SEL_SPENT, 1, 1);
        chk("rst_ovr0", SEL_OVR, 0, 0);
        chk("rst_ocnt0", SEL_OCNT, 0, 0);
        step(1);
        rst        = 1'b0;
        period     = 10;
        budget     = {32'd100, 32'd100};
        credit_cap = {32'd200, 32'd200};
        enable     = 1'b1;

        // k=0: first edge after release loads period and budgets
        step(1);
        chk("load_pleft", SEL_PLEFT, 0, 10);
        chk("load_pover", SEL_POVER, 0, 0);
        chk("load_bleft0", SEL_BLEFT, 0, 100);
        chk("load_bleft1", SEL_BLEFT, 1, 100);
        chk("load_spent0", SEL_SPENT, 0, 0);
        step(9);
        chk("cnt_pleft1", SEL_PLEFT, 0, 1);
        chk("cnt_pover_lo", SEL_POVER, 0, 0);
        step(1);
        chk("cnt_pleft0", SEL_PLEFT, 0, 0);
        chk("cnt_pover_hi", SEL_POVER, 0, 1);
        step(1);
        chk("reload_pleft", SEL_PLEFT, 0, 10);

        // k=11: ch0 spends 40 per cycle
        ax_happening = 2'b01;
        ax_bytes[0]  = 40;
        step(1);
        chk("spend_60", SEL_BLEFT, 0, 60);
        step(1);
        chk("spend_20", SEL_BLEFT, 0, 20);
        step(1);
        chk("spend_sat0", SEL_BLEFT, 0, 0);
        chk("spend_ovr0", SEL_OVR, 0, 1);
        chk("spend_spent0", SEL_SPENT, 0, 1);
        chk("spend_ch1", SEL_BLEFT, 1, 100);
        chk("spend_ovr1", SEL_OVR, 1, 0);
        // k=14: ch0 at zero is not charged; ch1 spends 90
        ax_happening = 2'b11;
        ax_bytes[1]  = 90;
        step(1);
        chk("zero_nocharge", SEL_BLEFT, 0, 0);
        chk("zero_noovr", SEL_OVR, 0, 0);
        chk("ch1_10", SEL_BLEFT, 1, 10);
        chk("ocnt_one", SEL_OCNT, 0, StatsEn ? 1 : 0);
        chk("pleft6", SEL_PLEFT, 0, 6);
        ax_happening = 2'b00;
        step(2);
        chk("abort_pre_pleft", SEL_PLEFT, 0, 4);
        period_abort = 1'b1;
        chk("abort_pover", SEL_POVER, 0, 1);
        step(1);
        period_abort = 1'b0;
        chk("abort_pleft", SEL_PLEFT, 0, 10);
        chk("abort_bleft1", SEL_BLEFT, 1, 100);
        chk("abort_bleft0", SEL_BLEFT, 0, 100);

        // k=18: enable low holds everything, traffic ignored
        enable       = 1'b0;
        ax_happening = 2'b01;
        ax_bytes[0]  = 5;
        step(1);
        chk("hold_pleft", SEL_PLEFT, 0, 10);
        chk("hold_bleft0", SEL_BLEFT, 0, 100);
        enable      = 1'b1;
        ax_bytes[0] = 95;
        step(1);
        chk("drain_5", SEL_BLEFT, 0, 5);
        ax_happening = 2'b00;
        step(9);
        chk("k29_pleft0", SEL_PLEFT, 0, 0);
        enable = 1'b0;
        step(1);
        chk("dis_repl_pleft", SEL_PLEFT, 0, 10);
        chk("dis_repl_bleft0", SEL_BLEFT, 0, 100);
        step(1);
        chk("dis_hold_pleft", SEL_PLEFT, 0, 10);

        // k=31: arrange left=5 at a replenish, then spend 30 on that edge
        enable       = 1'b1;
        ax_happening = 2'b01;
        ax_bytes[0]  = 95;
        step(1);
        ax_happening = 2'b00;
        step(9);
        chk("k41_bleft0", SEL_BLEFT, 0, 5);
        chk("k41_pover", SEL_POVER, 0, 1);
        ax_happening = 2'b01;
        ax_bytes[0]  = 30;
        step(1);
        chk("repl_spend_70", SEL_BLEFT, 0, 70);
        chk("repl_spend_noovr", SEL_OVR, 0, 0);

        // k=42: empty ch1 exactly (bytes == budget), switch it to CARRY
        ax_happening  = 2'b10;
        ax_bytes[1]   = 100;
        mode          = 2'b10;
        budget[1]     = 50;
        credit_cap[1] = 120;
        step(1);
        chk("exact_zero", SEL_BLEFT, 1, 0);
        chk("exact_noovr", SEL_OVR, 1, 0);
        chk("exact_spent", SEL_SPENT, 1, 1);
        ax_happening = 2'b00;
        period_abort = 1'b1;
        period       = 2;
        step(1);
        period_abort = 1'b0;
        chk("carry_50", SEL_BLEFT, 1, 50);
        chk("carry_pleft2", SEL_PLEFT, 0, 2);
        step(3);
        chk("carry_100", SEL_BLEFT, 1, 100);
        chk("carry_ch0_reload", SEL_BLEFT, 0, 100);
        step(3);
        chk("carry_cap120", SEL_BLEFT, 1, 120);
        step(3);
        chk("carry_hold120", SEL_BLEFT, 1, 120);
        budget[1]     = 32'hFFFF_FFF0;
        credit_cap[1] = 32'hFFFF_FFFF;
        step(3);
        chk("carry_nowrap", SEL_BLEFT, 1, 32'hFFFF_FFFF);
        credit_cap[1] = 100;
        step(3);
        chk("cap_below_budget", SEL_BLEFT, 1, 100);

        // k=59: zero-byte transaction
        ax_happening = 2'b01;
        ax_bytes[0]  = 0;
        step(1);
        chk("zero_bytes_bleft", SEL_BLEFT, 0, 100);
        chk("zero_bytes_noovr", SEL_OVR, 0, 0);
        ax_bytes[0] = 200;
        step(1);
        chk("ovr2_pulse", SEL_OVR, 0, 1);
        chk("ovr2_bleft", SEL_BLEFT, 0, 0);
        step(1);
        chk("ovr3_on_repl", SEL_OVR, 0, 1);
        chk("ocnt_two", SEL_OCNT, 0, StatsEn ? 2 : 0);
        step(1);
        chk("ovr_clear", SEL_OVR, 0, 0);
        chk("ocnt_three", SEL_OCNT, 0, StatsEn ? 3 : 0);
        step(2);
        chk("ovr4_pulse", SEL_OVR, 0, 1);
        step(5);
        chk("ocnt_sat", SEL_OCNT, 0, StatsEn ? 3 : 0);
        chk("ocnt_ch1", SEL_OCNT, 1, 0);
        ax_happening = 2'b00;

        step(2);
        draining = 1'b1;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
